pixel_stream_out: RTL

- Downstream stage of the shared result FIFO in the multi-engine Mandelbrot datapath.
- Pops {x, depth} entries from the FIFO's show-ahead read port and colour-maps each depth to 24-bit RGB.
- Emits pixels as an AXI4-Stream video stream to the display path: tuser marks start of frame, tlast marks end of line.
- Tracks column and row position and pulses frame_done at the end of each frame.

---
 rtl/pixel_stream_out.sv | 116 +++++++++++
 1 files changed

// File: rtl/pixel_stream_out.sv
// pixel_stream_out
//   Drains {x, depth} entries from a show-ahead result FIFO, colour-maps each
//   depth to 24-bit RGB and presents it as an AXI4-Stream video beat.
//   tuser marks the first pixel of a frame, and tlast marks the last pixel of
//   a line. frame_done pulses for one cycle after the last pixel of a frame
//   is accepted.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   enable              allows FIFO pops; low pauses without losing data
//   fifo_data_out       FIFO head {x[X_WIDTH], depth[ITER_WIDTH]}
//   fifo_empty          FIFO empty flag
//   fifo_read_en        pop strobe for the FIFO head
//   m_axis_*            AXI4-Stream video master (tdata = {R,G,B})
//   frame_done          one-cycle end-of-frame pulse
//   order_err           sticky x/column mismatch flag
//
// Optional build macro
//   PIXEL_ORDER_CHECK_EN  compares each popped x field with the column
//                         counter and sets order_err on a mismatch. When the
//                         macro is undefined, order_err is tied low.
module pixel_stream_out #(
  parameter int DATA_WIDTH = 20,
  parameter int X_WIDTH    = 10,
  parameter int ITER_WIDTH = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int MAX_ITER   = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic [23:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic                  order_err
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [ITER_WIDTH-1:0] MAX_D = ITER_WIDTH'(MAX_ITER);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  last_of_frame;
  logic [ITER_WIDTH-1:0] depth;
  logic [7:0]            d;
  logic [23:0]           rgb;
  logic                  col_last;
  logic                  row_last;

  assign depth    = fifo_data_out[ITER_WIDTH-1:0];
  assign d        = depth[7:0];
  assign col_last = (col == CW'(H_RES - 1));
  assign row_last = (row == RW'(V_RES - 1));

  // Cheap false-colour ramp; the bit drops are intended wrap-around banding.
  always_comb begin
    rgb = {d[5:0], 2'b00, d[6:0], 1'b0, d};
    if (depth >= MAX_D) rgb = 24'h000000;
  end

  // Pop only when the output register is empty or is being drained this cycle.
  assign fifo_read_en = enable && !fifo_empty && (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      last_of_frame <= 1'b0;
      frame_done    <= 1'b0;
      col           <= '0;
      row           <= '0;
    end else begin
      frame_done <= m_axis_tvalid && m_axis_tready && last_of_frame;
      if (fifo_read_en) begin
        m_axis_tdata  <= rgb;
        m_axis_tvalid <= 1'b1;
        m_axis_tuser  <= (col == '0) && (row == '0);
        m_axis_tlast  <= col_last;
        last_of_frame <= col_last && row_last;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef PIXEL_ORDER_CHECK_EN
  logic [X_WIDTH-1:0] x_field;
  assign x_field = fifo_data_out[DATA_WIDTH-1 -: X_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) order_err <= 1'b0;
    else if (fifo_read_en && (x_field != X_WIDTH'(col))) order_err <= 1'b1;
  end
`else
  logic unused_x_field;
  assign unused_x_field = ^fifo_data_out[DATA_WIDTH-1 -: X_WIDTH];
  assign order_err = 1'b0;
`endif

endmodule
